// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared constants and helpers for the arb_mux block.
//   MODE_SEL / MODE_RR : values of the mode input.
//   clog2_min1()       : index width that never collapses to zero bits.
package arb_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req_i       : per-channel request vector.
//   ptr_i       : last granted channel; search starts at ptr_i+1 and wraps.
//   gnt_valid_o : at least one request present.
//   gnt_idx_o   : index of the granted channel.
// Rotates the request vector so the highest-priority channel sits at bit 0,
// priority-encodes, then rotates the offset back to an absolute index.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic              gnt_valid_o,
    output logic [SEL_W-1:0]  gnt_idx_o
);

    logic [NUM_IN-1:0] req_rot;
    logic [SEL_W-1:0]  src_idx;
    logic [SEL_W-1:0]  offset;

    always_comb begin
        req_rot = '0;
        src_idx = '0;
        for (int unsigned j = 0; j < NUM_IN; j++) begin
            src_idx    = SEL_W'((j + 32'(ptr_i) + 1) % NUM_IN);
            req_rot[j] = req_i[src_idx];
        end
    end

    always_comb begin
        gnt_valid_o = 1'b0;
        offset      = '0;
        // Walk downward so the lowest set bit wins.
        for (int j = int'(NUM_IN) - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                gnt_valid_o = 1'b1;
                offset      = SEL_W'(j);
            end
        end
        gnt_idx_o = SEL_W'((32'(offset) + 32'(ptr_i) + 1) % NUM_IN);
    end

endmodule

// File: rtl/arb_mux.sv
// arb_mux: NUM_IN-input registered multiplexer with valid/ready handshakes.
//   clk, rst_n      : clock, asynchronous active-low reset.
//   in_data_i       : packed inputs, channel i at [i*WIDTH +: WIDTH].
//   in_valid_i      : per-channel valid.      in_ready_o : per-channel ready.
//   in_last_i       : per-channel burst end (only with ARB_MUX_LOCK_EN).
//   mode_i          : MODE_SEL (explicit sel_i) or MODE_RR (round-robin).
//   sel_i           : channel index for MODE_SEL; out-of-range means no grant.
//   out_data_o      : registered data.        out_src_o : producing channel.
//   out_valid_o     : output valid.           out_ready_i : consumer ready.
// Optional feature macro ARB_MUX_LOCK_EN: in MODE_RR a transfer with
// in_last=0 locks the grant to that channel until a transfer with in_last=1.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data_i,
    input  logic [NUM_IN-1:0]       in_valid_i,
    output logic [NUM_IN-1:0]       in_ready_o,
`ifdef ARB_MUX_LOCK_EN
    input  logic [NUM_IN-1:0]       in_last_i,
`endif
    input  logic                    mode_i,
    input  logic [SEL_W-1:0]        sel_i,
    output logic [WIDTH-1:0]        out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [SEL_W-1:0]        out_src_o
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             can_load;
    logic             xfer;
    logic             lock_q;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req_i       (in_valid_i),
        .ptr_i       (ptr_q),
        .gnt_valid_o (rr_valid),
        .gnt_idx_o   (rr_idx)
    );

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (mode_i == MODE_SEL) begin
            gnt_valid = (32'(sel_i) < NUM_IN);
            gnt_idx   = sel_i;
        end else if (lock_q) begin
            // ptr_q always holds the channel that took the lock.
            gnt_valid = 1'b1;
            gnt_idx   = ptr_q;
        end else begin
            gnt_valid = rr_valid;
            gnt_idx   = rr_idx;
        end
    end

    // rst_n gates ready so nothing is offered while reset is asserted.
    assign can_load = rst_n && (!out_valid_q || out_ready_i);

    always_comb begin
        in_ready_o = '0;
        gnt_data   = '0;
        xfer       = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                in_ready_o[i] = can_load && gnt_valid;
                gnt_data      = in_data_i[i*WIDTH +: WIDTH];
                xfer          = can_load && gnt_valid && in_valid_i[i];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_src_d   = gnt_idx;
            if (mode_i == MODE_RR) begin
                ptr_d = gnt_idx;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= SEL_W'(NUM_IN - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef ARB_MUX_LOCK_EN
    logic lock_d;
    logic gnt_last;

    always_comb begin
        gnt_last = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_last = in_last_i[i];
            end
        end
    end

    always_comb begin
        lock_d = lock_q;
        if (mode_i == MODE_SEL) begin
            lock_d = 1'b0;
        end else if (xfer) begin
            lock_d = !gnt_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign lock_q = 1'b0;
`endif

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: self-checking bench for arb_mux (4-channel instance checked every
// cycle against a behavioural model, plus a 5-channel instance for the
// out-of-range select case). Lock scenario runs when ARB_MUX_LOCK_EN is defined.
module tb_arb_mux;
    import arb_mux_pkg::*;

    localparam int N = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   dat [N];
    logic [N*8-1:0] in_data;
    logic [N-1:0] in_valid  = '0;
    logic [N-1:0] in_ready;
    logic [N-1:0] in_last   = '1;
    logic         mode      = MODE_SEL;
    logic [1:0]   sel       = '0;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [1:0]   out_src;

    logic [39:0]  d5_data  = 40'h55_44_33_22_11;
    logic [4:0]   d5_valid = '0;
    logic [4:0]   d5_ready;
    logic [2:0]   d5_sel   = '0;
    logic [7:0]   d5_out;
    logic         d5_ov;
    logic [2:0]   d5_src;

    int n_vec = 0;
    int n_err = 0;
    int rr_seq [6] = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    assign in_data = {dat[3], dat[2], dat[1], dat[0]};

    arb_mux #(.WIDTH(8), .NUM_IN(N)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
`ifdef ARB_MUX_LOCK_EN
        .in_last_i   (in_last),
`endif
        .mode_i      (mode),
        .sel_i       (sel),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_src_o   (out_src)
    );

    arb_mux #(.WIDTH(8), .NUM_IN(5)) u_dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (d5_data),
        .in_valid_i  (d5_valid),
        .in_ready_o  (d5_ready),
`ifdef ARB_MUX_LOCK_EN
        .in_last_i   (5'h1f),
`endif
        .mode_i      (MODE_SEL),
        .sel_i       (d5_sel),
        .out_data_o  (d5_out),
        .out_valid_o (d5_ov),
        .out_ready_i (1'b1),
        .out_src_o   (d5_src)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: output beat, RR pointer and lock flag.
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = '0;
    int         m_src   = 0;
    int         m_ptr   = N - 1;
    logic       m_lock  = 1'b0;

    function automatic int m_grant();
        if (mode == MODE_SEL) return (int'(sel) < N) ? int'(sel) : -1;
        if (m_lock) return m_ptr;
        for (int k = 1; k <= N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int g = m_grant();
        logic [N-1:0] r = '0;
        if (rst_n && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int   g;
        logic x;
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_src   <= 0;
            m_ptr   <= N - 1;
            m_lock  <= 1'b0;
        end else begin
            g = m_grant();
            x = (g >= 0) && (!m_valid || out_ready) && in_valid[g];
            if (x) begin
                m_valid <= 1'b1;
                m_data  <= in_data[g*8 +: 8];
                m_src   <= g;
                if (mode == MODE_RR) m_ptr <= g;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
`ifdef ARB_MUX_LOCK_EN
            if (mode == MODE_SEL) m_lock <= 1'b0;
            else if (x) m_lock <= !in_last[g];
`endif
        end
    end

    always @(negedge clk) begin : compare
        check("cyc_in_ready", 32'(in_ready), 32'(m_ready()));
        check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
        check("cyc_out_data", 32'(out_data), 32'(m_data));
        check("cyc_out_src", 32'(out_src), 32'(m_src));
    end

    // One clock; producers advance data on channels that were accepted.
    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) dat[i] = dat[i] + 8'h11;
        end
    endtask

    initial begin : watchdog
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : main
        logic [7:0] exp_d;
        for (int i = 0; i < N; i++) dat[i] = 8'(16 * i + 1);

        // Reset: ready must stay low even with every input valid.
        mode     = MODE_RR;
        in_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_src", 32'(out_src), 32'h0);
        in_valid = '0;
        rst_n    = 1'b1;

        // Explicit select.
        mode     = MODE_SEL;
        sel      = 2'd2;
        dat[2]   = 8'hA5;
        in_valid = 4'b0100;
        d5_sel   = 3'd5;
        d5_valid = 5'h1f;
        #1;
        check("sel_ready", 32'(in_ready), 32'b0100);
        check("sel5_oob_ready", 32'(d5_ready), 32'h0);
        tick();
        check("sel_data", 32'(out_data), 32'hA5);
        check("sel_src", 32'(out_src), 32'd2);
        check("sel_valid", 32'(out_valid), 32'd1);
        check("sel5_oob_noload", 32'(d5_ov), 32'd0);
        d5_sel   = 3'd4;
        sel      = 2'd1;
        in_valid = '0;
        #1;
        check("sel5_ready4", 32'(d5_ready), 32'b10000);
        check("sel_noreq_ready", 32'(in_ready), 32'b0010);
        tick();
        check("sel5_data", 32'(d5_out), 32'h55);
        check("sel5_src", 32'(d5_src), 32'd4);
        check("sel_drain", 32'(out_valid), 32'd0);
        d5_valid = '0;

        // Round-robin, all valid, back-to-back.
        mode     = MODE_RR;
        in_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            exp_d = dat[rr_seq[k]];
            tick();
            check("rr_src", 32'(out_src), 32'(rr_seq[k]));
            check("rr_valid", 32'(out_valid), 32'd1);
            check("b2b_data", 32'(out_data), 32'(exp_d));
        end
        tick();
        check("rr_src_pre_rst", 32'(out_src), 32'd2);

        // Async reset with a beat held, pointer at 2.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_first_rr", 32'(out_src), 32'd0);

        // Stall: channels 1 and 3, consumer blocks 3 cycles.
        in_valid = 4'b1010;
        exp_d    = dat[1];
        tick();
        check("stall_first_src", 32'(out_src), 32'd1);
        out_ready = 1'b0;
        repeat (3) begin
            #1;
            check("stall_ready", 32'(in_ready), 32'h0);
            tick();
            check("stall_src", 32'(out_src), 32'd1);
            check("stall_data", 32'(out_data), 32'(exp_d));
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", 32'(in_ready), 32'b1000);
        tick();
        check("stall_next_src", 32'(out_src), 32'd3);

`ifdef ARB_MUX_LOCK_EN
        // Burst lock on channel 1.
        in_valid = '0;
        tick();
        in_valid = 4'b0111;
        in_last  = 4'b0101;
        tick();
        check("lock_pre_src", 32'(out_src), 32'd0);
        tick();
        check("lock_b1_src", 32'(out_src), 32'd1);
        tick();
        check("lock_b2_src", 32'(out_src), 32'd1);
        in_valid[1] = 1'b0;
        #1;
        check("lock_hold_ready", 32'(in_ready), 32'b0010);
        tick();
        check("lock_gap_valid", 32'(out_valid), 32'd0);
        in_valid[1] = 1'b1;
        in_last[1]  = 1'b1;
        tick();
        check("lock_b3_src", 32'(out_src), 32'd1);
        tick();
        check("lock_release_src", 32'(out_src), 32'd2);
`endif

        in_valid = '0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
